// File: rtl/line_mem_responder_if.sv
// Request/response bundle between dcache_controller and line_mem_responder.
//   addr_i   : byte address of the line. Bits [4:0] are ignored.
//   enable_i : request valid.
//   write_i  : 1 = line write, 0 = line read. Sampled with enable_i.
//   data_i   : write data. Sampled with enable_i.
//   ack_o    : one-cycle completion pulse.
//   data_o   : read data. Valid while ack_o is high for a read.
//   busy_o   : a request is in flight.
// master = controller side, slave = memory responder side.
interface line_mem_responder_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);
   logic [ADDR_W-1:0] addr_i;
   logic              enable_i;
   logic              write_i;
   logic [LINE_W-1:0] data_i;
   logic              ack_o;
   logic [LINE_W-1:0] data_o;
   logic              busy_o;

   modport master (
      output addr_i, enable_i, write_i, data_i,
      input  ack_o, data_o, busy_o
   );

   modport slave (
      input  addr_i, enable_i, write_i, data_i,
      output ack_o, data_o, busy_o
   );
endinterface

// File: rtl/line_mem_responder.sv
// Main-memory stand-in for dcache_controller.
// Each request reads or writes one line and completes with a single-cycle ack
// after a fixed access latency.
// Ports:
//   clk_i : clock, rising edge.
//   rst_i : asynchronous active-low reset. Stored lines are not cleared.
//   bus   : slave modport of line_mem_responder_if. It carries the request,
//           ack, read data and busy signals.
module line_mem_responder #(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 256,
   parameter int DEPTH   = 512,
   parameter int LATENCY = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   line_mem_responder_if.slave   bus
);
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t             r_state;
   logic [7:0]         r_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic               r_wr;
   logic [LINE_W-1:0]  r_data;
   logic [LINE_W-1:0]  r_rdata;
   logic               r_ack;
   logic               r_busy;
   logic [LINE_W-1:0]  r_mem [DEPTH];

   logic [IDX_W-1:0]   w_idx_in;
   logic               w_commit;
   logic [IDX_W-1:0]   w_cm_idx;
   logic               w_cm_wr;
   logic [LINE_W-1:0]  w_cm_data;
   logic               w_unused_addr;

   // Upper address bits fall outside the line index and wrap modulo DEPTH lines.
   assign w_idx_in      = bus.addr_i[5 +: IDX_W];
   assign w_unused_addr = ^{bus.addr_i[ADDR_W-1:5+IDX_W], bus.addr_i[4:0]};

   // The commit edge is the edge that enters ACK.
   // With LATENCY==1 this is the acceptance edge, so the live inputs are used
   // instead of the latched ones.
   // Gating with rst_i keeps an edge that arrives during reset from writing memory.
   assign w_commit  = rst_i &&
                      (((r_state == IDLE) && bus.enable_i && (LATENCY == 1)) ||
                       ((r_state == WAIT) && (r_cnt == 8'd1)));
   assign w_cm_idx  = (r_state == IDLE) ? w_idx_in     : r_idx;
   assign w_cm_wr   = (r_state == IDLE) ? bus.write_i  : r_wr;
   assign w_cm_data = (r_state == IDLE) ? bus.data_i   : r_data;

   // Storage has no reset, so it sits in its own block.
   always_ff @(posedge clk_i) begin
      if (w_commit && w_cm_wr) begin
         r_mem[w_cm_idx] <= w_cm_data;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_wr    <= 1'b0;
         r_data  <= '0;
         r_rdata <= '0;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         if (w_commit && !w_cm_wr) begin
            r_rdata <= r_mem[w_cm_idx];
         end
         unique case (r_state)
            IDLE: begin
               if (bus.enable_i) begin
                  r_idx  <= w_idx_in;
                  r_wr   <= bus.write_i;
                  r_data <= bus.data_i;
                  r_busy <= 1'b1;
                  if (LATENCY == 1) begin
                     r_state <= ACK;
                     r_ack   <= 1'b1;
                  end else begin
                     r_cnt   <= 8'(LATENCY - 1);
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 8'd1;
               if (r_cnt == 8'd1) begin
                  r_state <= ACK;
                  r_ack   <= 1'b1;
               end
            end
            ACK: begin
               // No acceptance here: enable_i held high is taken on the following IDLE cycle.
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.ack_o  = r_ack;
   assign bus.busy_o = r_busy;
   assign bus.data_o = r_rdata;
endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder.
// Two instances, one with LATENCY=10 and one with LATENCY=1, receive identical
// stimulus.
// A timeline model predicts ack, busy and data_o for each instance on every cycle.
// For each request the model works out the ack cycle and the commit effect.
module tb_line_mem_responder;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [31:0]  addr = '0;
   logic         en = 1'b0;
   logic         wr = 1'b0;
   logic [255:0] din = '0;

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   line_mem_responder_if #(.ADDR_W(32), .LINE_W(256)) bus0 ();
   line_mem_responder_if #(.ADDR_W(32), .LINE_W(256)) bus1 ();

   assign bus0.addr_i = addr;  assign bus0.enable_i = en;
   assign bus0.write_i = wr;   assign bus0.data_i = din;
   assign bus1.addr_i = addr;  assign bus1.enable_i = en;
   assign bus1.write_i = wr;   assign bus1.data_i = din;

   line_mem_responder #(.ADDR_W(32), .LINE_W(256), .DEPTH(512), .LATENCY(10)) dut0 (
      .clk_i(clk), .rst_i(rst_n), .bus(bus0));
   line_mem_responder #(.ADDR_W(32), .LINE_W(256), .DEPTH(512), .LATENCY(1)) dut1 (
      .clk_i(clk), .rst_i(rst_n), .bus(bus1));

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- timeline model ----------------
   // Cycle k is the interval after posedge k.
   // A request accepted at posedge k acks in cycle k+LAT-1 and is busy from cycle k
   // through that ack cycle.
   // A new request may be taken no earlier than two edges after the ack cycle.
   int           cyc = 0;
   bit           pend [2];
   int           acy [2];
   logic [8:0]   midx [2];
   bit           mwr [2];
   logic [255:0] mdat [2];
   logic [255:0] mrd [2];
   logic [255:0] mmem [2][512];

   function automatic int lat(input int d);
      return (d == 0) ? 10 : 1;
   endfunction

   initial begin
      for (int d = 0; d < 2; d++) begin pend[d] = 0; acy[d] = -100; mrd[d] = '0; end
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin pend[d] = 0; acy[d] = -100; mrd[d] = '0; end
         end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
               if (pend[d] && cyc == acy[d] + 1) pend[d] = 0;
               if (!pend[d] && cyc >= acy[d] + 2 && en) begin
                  pend[d] = 1;
                  acy[d]  = cyc + lat(d) - 1;
                  midx[d] = addr[13:5];
                  mwr[d]  = wr;
                  mdat[d] = din;
               end
               if (pend[d] && cyc == acy[d]) begin
                  if (mwr[d]) mmem[d][midx[d]] = mdat[d];
                  else        mrd[d] = mmem[d][midx[d]];
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (check_en) begin
            chk("ack0",  bus0.ack_o,  256'(pend[0] && cyc == acy[0]));
            chk("busy0", bus0.busy_o, 256'(pend[0]));
            chk("data0", bus0.data_o, mrd[0]);
            chk("ack1",  bus1.ack_o,  256'(pend[1] && cyc == acy[1]));
            chk("busy1", bus1.busy_o, 256'(pend[1]));
            chk("data1", bus1.data_o, mrd[1]);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   int           w_first [2];
   int           w_nack [2];
   int           w_nbusy [2];
   logic [255:0] w_dat [2];

   // Observe n cycles after an acceptance edge.
   // At cycle chg (if nonzero), move addr to 0xC0 and drop enable.
   task automatic watch(input int n, input int chg);
      for (int d = 0; d < 2; d++) begin
         w_first[d] = -1; w_nack[d] = 0; w_nbusy[d] = 0; w_dat[d] = '0;
      end
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         if (bus0.ack_o) begin
            if (w_first[0] < 0) begin w_first[0] = c; w_dat[0] = bus0.data_o; end
            w_nack[0]++;
         end
         if (bus1.ack_o) begin
            if (w_first[1] < 0) begin w_first[1] = c; w_dat[1] = bus1.data_o; end
            w_nack[1]++;
         end
         if (bus0.busy_o) w_nbusy[0]++;
         if (bus1.busy_o) w_nbusy[1]++;
         if (c == chg) begin addr = 32'h0000_00C0; en = 1'b0; end
      end
   endtask

   task automatic req(input logic [31:0] ad, input logic w, input logic [255:0] dt, input bit drop);
      @(posedge clk); #1;
      addr = ad; wr = w; din = dt; en = 1'b1;
      @(posedge clk); #1;
      if (drop) en = 1'b0;
   endtask

   logic [255:0] D_A, D_B, D_C, D_D, D_E, D_F, D_G;
   int cA, cB;

   initial begin
      D_A = {8{32'hA5A5_0001}};
      D_B = {8{32'h3C3C_0002}};
      D_C = {8{32'h1111_0003}};
      D_D = {8{32'h2222_0004}};
      D_E = {8{32'h4444_0005}};
      D_F = {8{32'h5555_0006}};
      D_G = {8{32'h6666_0007}};

      // Outputs are zero while reset is held.
      #12;
      chk("rst_ack0", bus0.ack_o, '0);
      chk("rst_busy0", bus0.busy_o, '0);
      chk("rst_data0", bus0.data_o, '0);
      @(posedge clk); #1 rst_n = 1'b1;
      check_en = 1'b1;

      // Write then read line 0x40. Also pins LATENCY=1 timing and single-cycle busy.
      req(32'h0000_0040, 1'b1, D_A, 1'b1); watch(12, 0);
      chk("wr_lat0", w_first[0], 10);
      chk("wr_nack0", w_nack[0], 1);
      chk("wr_busy0", w_nbusy[0], 10);
      chk("wr_lat1", w_first[1], 1);
      chk("wr_busy1", w_nbusy[1], 1);
      req(32'h0000_0040, 1'b0, '0, 1'b1); watch(12, 0);
      chk("rd_lat0", w_first[0], 10);
      chk("rd_data0", w_dat[0], D_A);
      chk("rd_data1", w_dat[1], D_A);
      chk("rd_lat1", w_first[1], 1);

      // Address wrap: 0x4040 aliases line index 2.
      req(32'h0000_4040, 1'b1, D_B, 1'b1); watch(12, 0);
      req(32'h0000_0040, 1'b0, '0, 1'b1); watch(12, 0);
      chk("wrap_data0", w_dat[0], D_B);
      chk("wrap_data1", w_dat[1], D_B);

      // Reset mid-WAIT drops an uncommitted write.
      // The LATENCY=1 instance commits its write at the acceptance edge.
      req(32'h0000_0100, 1'b1, D_C, 1'b1); watch(12, 0);
      req(32'h0000_0100, 1'b1, D_D, 1'b1);
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_ack0", bus0.ack_o, '0);
      chk("mid_rst_busy0", bus0.busy_o, '0);
      chk("mid_rst_data0", bus0.data_o, '0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      watch(15, 0);
      chk("post_rst_nack0", w_nack[0], 0);
      chk("post_rst_busy0", w_nbusy[0], 0);
      req(32'h0000_0100, 1'b0, '0, 1'b1); watch(12, 0);
      chk("cut_wr_data0", w_dat[0], D_C);
      chk("cut_wr_data1", w_dat[1], D_D);

      // Input stability: read 0x80, then move addr and drop enable at cycle 3.
      req(32'h0000_0080, 1'b1, D_E, 1'b1); watch(12, 0);
      req(32'h0000_00C0, 1'b1, D_F, 1'b1); watch(12, 0);
      req(32'h0000_0080, 1'b0, '0, 1'b0); watch(14, 3);
      chk("stab_lat0", w_first[0], 10);
      chk("stab_nack0", w_nack[0], 1);
      chk("stab_data0", w_dat[0], D_E);

      // Back-to-back with enable held: write line A, then read line B starting on the ack cycle.
      @(posedge clk); #1;
      addr = 32'h0000_01E0; wr = 1'b1; din = D_G; en = 1'b1;
      cA = -1; cB = -1;
      for (int c = 1; c <= 40 && cB < 0; c++) begin
         @(negedge clk);
         if (bus0.ack_o) begin
            if (cA < 0) begin
               cA = c; wr = 1'b0; addr = 32'h0000_0080; din = {8{32'hDEAD_BEEF}};
            end else begin
               cB = c; w_dat[0] = bus0.data_o; en = 1'b0;
            end
         end
      end
      chk("b2b_spacing0", cB - cA, 11);
      chk("b2b_data0", w_dat[0], D_E);
      repeat (4) @(negedge clk);
      req(32'h0000_01E0, 1'b0, '0, 1'b1); watch(12, 0);
      chk("b2b_A_data0", w_dat[0], D_G);
      chk("b2b_A_data1", w_dat[1], D_G);

      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
